// File: rtl/traffic_controller_nway_pkg.sv
// Shared types and lamp codes for the N-way intersection controller.
package traffic_pkg;

   // Controller phases
   typedef enum logic [2:0] {
      ST_ALL_RED = 3'd0,
      ST_GREEN   = 3'd1,
      ST_YELLOW  = 3'd2,
      ST_WALK    = 3'd3,
      ST_FLASH   = 3'd4
   } state_t;

   // Per-way lamp codes, packed as {red, yellow, green}
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

endpackage

// File: rtl/traffic_controller_nway_rr_next_way.sv
// Round-robin picker: first pending way after the current one, current way last.
module rr_next_way
   import traffic_pkg::*;
#(
   parameter int N_WAYS = 4,
   parameter int WAY_W  = $clog2(N_WAYS)
) (
   input  logic [N_WAYS-1:0] i_reqPend,
   input  logic [WAY_W-1:0]  i_curWay,
   output logic [WAY_W-1:0]  o_nextWay,
   output logic              o_found
);

   int               w_idx;
   logic [WAY_W-1:0] w_cand;

   // Walk offsets 1..N_WAYS from the current way, keeping the first hit
   always_comb begin
      o_nextWay = i_curWay;
      o_found   = 1'b0;
      w_idx     = 0;
      w_cand    = '0;
      for (int off = 1; off <= N_WAYS; off++) begin
         w_idx = int'(i_curWay) + off;
         if (w_idx >= N_WAYS) begin
            w_idx = w_idx - N_WAYS;
         end
         w_cand = WAY_W'(w_idx);
         if (!o_found && i_reqPend[w_cand]) begin
            o_nextWay = w_cand;
            o_found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/traffic_controller_nway.sv
// N-way intersection controller: latched requests served round-robin with
// green/yellow/all-red timing, a pedestrian walk phase and flashing fault mode.
module traffic_controller_nway
   import traffic_pkg::*;
#(
   parameter int N_WAYS   = 4,
   parameter int CNT_W    = 8,
   parameter int GREEN_T  = 8,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 2,
   parameter int WALK_T   = 6,
   parameter int FLASH_T  = 4
) (
   input  logic                      clk,
   input  logic                      res_n,
   input  logic                      en,
   input  logic [N_WAYS-1:0]         req,
   input  logic                      ped_req,
   input  logic                      flash,
   output logic [3*N_WAYS-1:0]       lights,
   output logic                      walk,
   output logic [$clog2(N_WAYS)-1:0] cur_way
);

   localparam int               WAY_W     = $clog2(N_WAYS);
   localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
   localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_T - 1);
   localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
   localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(N_WAYS - 1);

   state_t                r_state;
   state_t                w_stateNxt;
   logic [CNT_W-1:0]      r_timer;
   logic [CNT_W-1:0]      w_timerNxt;
   logic [WAY_W-1:0]      r_curWay;
   logic [WAY_W-1:0]      w_curWayNxt;
   logic                  r_flashPh;
   logic                  w_flashPhNxt;
   logic [N_WAYS-1:0]     r_reqPend;
   logic                  r_pedPend;
   logic [3*N_WAYS-1:0]   r_lights;
   logic [3*N_WAYS-1:0]   w_lightsNxt;
   logic                  r_walk;
   logic                  w_walkNxt;
   logic [2:0]            w_seg;
   logic                  w_expired;
   logic                  w_enterGreen;
   logic                  w_enterWalk;
   logic [N_WAYS-1:0]     w_curMask;
   logic [N_WAYS-1:0]     w_nxtMask;
   logic [N_WAYS-1:0]     w_greenMask;
   logic [N_WAYS-1:0]     w_clrMask;
   logic [N_WAYS-1:0]     w_otherPend;
   logic [WAY_W-1:0]      w_rrWay;
   logic                  w_rrFound;

   assign w_expired   = (r_timer == '0);
   assign w_greenMask = (r_state == ST_GREEN) ? w_curMask : '0;
   assign w_clrMask   = w_enterGreen ? w_nxtMask : '0;
   assign w_otherPend = r_reqPend & ~w_curMask;

   assign lights  = r_lights;
   assign walk    = r_walk;
   assign cur_way = r_curWay;

   rr_next_way #(
      .N_WAYS (N_WAYS),
      .WAY_W  (WAY_W)
   ) u_rrNextWay (
      .i_reqPend (r_reqPend),
      .i_curWay  (r_curWay),
      .o_nextWay (w_rrWay),
      .o_found   (w_rrFound)
   );

   // One-hot masks of the current way and of the way about to be current
   always_comb begin
      w_curMask = '0;
      w_nxtMask = '0;
      for (int i = 0; i < N_WAYS; i++) begin
         w_curMask[i] = (WAY_W'(i) == r_curWay);
         w_nxtMask[i] = (WAY_W'(i) == w_curWayNxt);
      end
   end

   // Next phase, timer, served way and flash phase; everything holds while en=0
   always_comb begin
      w_stateNxt   = r_state;
      w_timerNxt   = r_timer;
      w_curWayNxt  = r_curWay;
      w_flashPhNxt = r_flashPh;
      w_enterGreen = 1'b0;
      w_enterWalk  = 1'b0;
      if (en) begin
         if (flash && (r_state != ST_FLASH)) begin
            w_stateNxt   = ST_FLASH;
            w_timerNxt   = FLASH_LD;
            w_flashPhNxt = 1'b1;
         end else begin
            case (r_state)
               ST_ALL_RED: begin
                  if (!w_expired) begin
                     w_timerNxt = r_timer - CNT_W'(1);
                  end else if (r_pedPend) begin
                     w_stateNxt  = ST_WALK;
                     w_timerNxt  = WALK_LD;
                     w_enterWalk = 1'b1;
                  end else if (w_rrFound) begin
                     w_stateNxt   = ST_GREEN;
                     w_timerNxt   = GREEN_LD;
                     w_curWayNxt  = w_rrWay;
                     w_enterGreen = 1'b1;
                  end
               end
               ST_GREEN: begin
                  if (!w_expired) begin
                     w_timerNxt = r_timer - CNT_W'(1);
                  end else if ((|w_otherPend) || r_pedPend) begin
                     w_stateNxt = ST_YELLOW;
                     w_timerNxt = YELLOW_LD;
                  end
               end
               ST_YELLOW, ST_WALK: begin
                  if (!w_expired) begin
                     w_timerNxt = r_timer - CNT_W'(1);
                  end else begin
                     w_stateNxt = ST_ALL_RED;
                     w_timerNxt = ALLRED_LD;
                  end
               end
               ST_FLASH: begin
                  if (!flash) begin
                     w_stateNxt = ST_ALL_RED;
                     w_timerNxt = ALLRED_LD;
                  end else if (w_expired) begin
                     w_flashPhNxt = ~r_flashPh;
                     w_timerNxt   = FLASH_LD;
                  end else begin
                     w_timerNxt = r_timer - CNT_W'(1);
                  end
               end
               default: begin
                  w_stateNxt = ST_ALL_RED;
                  w_timerNxt = ALLRED_LD;
               end
            endcase
         end
      end
   end

   // Lamp decode of the upcoming phase so the registered outputs track the state
   always_comb begin
      w_lightsNxt = '0;
      w_seg       = LAMP_RED;
      for (int i = 0; i < N_WAYS; i++) begin
         case (w_stateNxt)
            ST_FLASH:  w_seg = w_flashPhNxt ? LAMP_YEL : LAMP_OFF;
            ST_GREEN:  w_seg = w_nxtMask[i] ? LAMP_GRN : LAMP_RED;
            ST_YELLOW: w_seg = w_nxtMask[i] ? LAMP_YEL : LAMP_RED;
            default:   w_seg = LAMP_RED;
         endcase
         w_lightsNxt[3*i +: 3] = w_seg;
      end
      w_walkNxt = (w_stateNxt == ST_WALK);
   end

   // Phase, timer and output registers
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_state   <= ST_ALL_RED;
         r_timer   <= ALLRED_LD;
         r_curWay  <= LAST_WAY;
         r_flashPh <= 1'b0;
         r_lights  <= {N_WAYS{LAMP_RED}};
         r_walk    <= 1'b0;
      end else begin
         r_state   <= w_stateNxt;
         r_timer   <= w_timerNxt;
         r_curWay  <= w_curWayNxt;
         r_flashPh <= w_flashPhNxt;
         r_lights  <= w_lightsNxt;
         r_walk    <= w_walkNxt;
      end
   end

   // Request latches keep collecting while frozen; clearing on service wins over a new set
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         r_reqPend <= '0;
         r_pedPend <= 1'b0;
      end else begin
         r_reqPend <= (r_reqPend | (req & ~w_greenMask)) & ~w_clrMask;
         r_pedPend <= (r_pedPend | ped_req) & ~w_enterWalk;
      end
   end

endmodule

// File: doc/traffic_controller_nway.md
Name: traffic_controller_nway

Overview:
Parametrised N-way intersection controller; successor to the 2-input Mealy traffic controller. Latches vehicle requests per approach and serves them round-robin with minimum-green, yellow and all-red clearance timing. Adds a latched pedestrian walk phase, an enable freeze and a flashing-yellow fault mode. Sits between sensor/debounce logic and the lamp drivers.

Parameters:
N_WAYS, 4, number of approaches (2..8)
CNT_W, 8, phase timer width
GREEN_T, 8, minimum green cycles (1..2^CNT_W)
YELLOW_T, 3, yellow cycles
ALLRED_T, 2, all-red clearance cycles
WALK_T, 6, pedestrian walk cycles
FLASH_T, 4, flash half-period cycles

Ports:
clk  in  1  clock
res_n  in  1  asynchronous active-low reset
en  in  1  1 = run; 0 = freeze FSM, timer and outputs (request latching continues)
req  in  N_WAYS  vehicle request per approach, one-cycle pulse sufficient
ped_req  in  1  pedestrian button, pulse sufficient
flash  in  1  level; 1 = flashing-yellow mode
lights  out  3*N_WAYS  per way {red,yellow,green}; way i at bits [3i+2:3i]
walk  out  1  pedestrian walk lamp
cur_way  out  $clog2(N_WAYS)  way currently or most recently green

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on res_n. All outputs registered, decoded from state.
- Reset: state ALL_RED, timer=ALLRED_T-1, cur_way=N_WAYS-1 (so way 0 is first in round-robin), req_pend=0, ped_pend=0, flash_ph=0, lights all 3'b100, walk=0.
- Each timed state lasts exactly T enabled cycles: timer loads T-1 on entry, decrements per enabled cycle; expiry when timer==0.
- States: ALL_RED, GREEN, YELLOW, WALK, FLASH.
- ALL_RED: all red. On expiry: ped_pend -> WALK (clear ped_pend); else any req_pend -> GREEN for the first pending way searching cur_way+1, cur_way+2, ... wrapping modulo N_WAYS (cur_way itself searched last); else remain ALL_RED, timer held at 0, re-evaluated every cycle.
- GREEN: way cur_way 3'b001, others 3'b100. On expiry: if any req_pend for another way or ped_pend -> YELLOW; else hold GREEN (rest-in-green), timer held at 0.
- YELLOW: cur_way 3'b010, others red; expiry -> ALL_RED.
- WALK: all red, walk=1; expiry -> ALL_RED.
- FLASH: every way 3'b010 when flash_ph=1, 3'b000 when 0; flash_ph toggles every FLASH_T cycles, starting at 1 on entry; walk=0.
- flash=1 overrides: from any state, next enabled cycle enters FLASH. flash=0 in FLASH -> ALL_RED with full ALLRED_T clearance. Pending requests retained across FLASH.
- Request latching: req_pend[i] set by req[i] every cycle (even when en=0), except req[i] for the way that is GREEN is ignored. On entry to GREEN of way k, req_pend[k] clears; clear wins over a same-cycle set. ped_pend set by ped_req; a same-cycle set and clear on WALK entry leaves ped_pend=0.
- en=0: state, timer, flash_ph, cur_way and outputs hold; resuming continues the remaining count.
- res_n low at any time: immediate return to reset values, pending requests discarded.

Decomposition:
- Package traffic_pkg: state enum, lamp codes LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001, LAMP_OFF=3'b000.
- Sub-module rr_next_way (combinational): inputs req_pend and cur_way; outputs next way and a found flag. FSM, timer and latches stay in the top module.

Test Plan:
- Reset release, req[2] pulse at cycle 0 -> all red 2 cycles, then way 2 green; with no further requests it stays green indefinitely and cur_way=2.
- Way 2 green with timer expired; req[0] and req[3] pulsed together -> 3 cycles yellow on way 2, 2 all red, 8+ green way 3, then yellow/all-red, then way 0 green.
- ped_req pulse during way 1 green, req[3] pending -> yellow 3, all red 2, walk=1 for 6 cycles, all red 2, then way 3 green.
- en=0 for 5 cycles after the 1st yellow cycle -> lights frozen at yellow; after en=1, exactly 2 more yellow cycles.
- flash=1 during green -> next cycle all ways 3'b010, toggling to 3'b000 every 4 cycles; flash=0 -> all red 2 cycles, then earlier pending request is served.
- res_n low mid-green with req_pend=4'b1010 -> lights all red asynchronously, walk=0; after release with no requests, controller holds all red.
